// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C master engine
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WR_ACK,
    ST_READ,
    ST_RD_ACK,
    ST_STOP
  } state_t;

  // Q0/Q1 hold SCL low, Q2/Q3 hold SCL high
  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quarter_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_bit_timer.sv
// rtl/i2c_bit_timer.sv - quarter-phase sequencer and bit strobes for the I2C engine
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic     clk,
  input  logic     rst_,
  input  logic     clear,
  output quarter_t quarter,
  output logic     q_last,
  output logic     sample,
  output logic     bit_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt <= '0;
      q   <= '0;
    end else if (clear) begin
      cnt <= '0;
      q   <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      q   <= q + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign quarter = quarter_t'(q);
  assign q_last  = (cnt == LAST);
  assign sample  = q_last && (quarter == Q2);
  assign bit_end = q_last && (quarter == Q3);

endmodule

// File: rtl/i2c_master_engine.sv
// rtl/i2c_master_engine.sv - single-master I2C byte engine with start/stop framing
module i2c_master_engine
  import i2c_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 4,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       slave_addr,
  input  logic [CNT_W-1:0] num_bytes,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             nack_err,
  input  logic             sda_in,
  output logic             scl_out,
  output logic             sda_out,
  output logic             sda_select
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  state_t           state, state_next;
  quarter_t         quarter;
  logic             q_last, sample, bit_end, timer_clear;
  logic [3:0]       bit_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic [7:0]       shift;
  logic             rw_q, ack_bit, nack_seen;
  logic             scl_phase, last_data_bit, ack_state, finishing;

  // START is two quarters long, so the timer restarts to align ADDR to Q0
  assign timer_clear = (state == ST_IDLE) || (state == ST_START && quarter == Q1 && q_last);

  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk     (clk),
    .rst_    (rst_),
    .clear   (timer_clear),
    .quarter (quarter),
    .q_last  (q_last),
    .sample  (sample),
    .bit_end (bit_end)
  );

  assign scl_phase     = (quarter == Q2) || (quarter == Q3);
  assign last_data_bit = bit_end && (bit_cnt == 4'd7);
  assign ack_state     = (state == ST_ADDR_ACK) || (state == ST_WR_ACK);
  assign finishing     = (state == ST_STOP) && (state_next == ST_IDLE);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    scl_out    = 1'b1;
    sda_out    = 1'b1;
    sda_select = 1'b1;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_START;
      end
      ST_START: begin
        sda_out    = 1'b0;
        sda_select = 1'b0;
        if (quarter == Q1 && q_last) state_next = ST_ADDR;
      end
      ST_ADDR: begin
        scl_out    = scl_phase;
        sda_out    = shift[7];
        sda_select = 1'b0;
        if (last_data_bit) state_next = ST_ADDR_ACK;
      end
      ST_ADDR_ACK: begin
        scl_out = scl_phase;
        if (bit_end) begin
          if (ack_bit == NACK || byte_cnt == '0) state_next = ST_STOP;
          else                                   state_next = rw_q ? ST_READ : ST_WRITE;
        end
      end
      ST_WRITE: begin
        scl_out    = scl_phase;
        // on the capture cycle the shifter still holds the previous byte
        sda_out    = wr_ready ? wr_data[7] : shift[7];
        sda_select = 1'b0;
        if (last_data_bit) state_next = ST_WR_ACK;
      end
      ST_WR_ACK: begin
        scl_out = scl_phase;
        if (bit_end) state_next = (ack_bit == NACK || byte_cnt == '0) ? ST_STOP : ST_WRITE;
      end
      ST_READ: begin
        scl_out = scl_phase;
        if (last_data_bit) state_next = ST_RD_ACK;
      end
      ST_RD_ACK: begin
        scl_out    = scl_phase;
        sda_select = 1'b0;
        sda_out    = (byte_cnt != '0) ? ACK : NACK;
        if (bit_end) state_next = (byte_cnt != '0) ? ST_READ : ST_STOP;
      end
      ST_STOP: begin
        scl_out = (quarter != Q0);
        if (quarter == Q0 || quarter == Q1) begin
          sda_out    = 1'b0;
          sda_select = 1'b0;
        end
        if (quarter == Q2 && q_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      nack_err  <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      shift     <= '0;
      rw_q      <= 1'b0;
      ack_bit   <= NACK;
      nack_seen <= 1'b0;
    end else begin
      busy     <= (state_next != ST_IDLE);
      done     <= finishing;
      nack_err <= finishing && nack_seen;
      wr_ready <= (state_next == ST_WRITE) && (state != ST_WRITE);
      rd_valid <= (state == ST_READ) && last_data_bit;

      if (state == ST_IDLE || state == ST_START) bit_cnt <= '0;
      else if (bit_end)                          bit_cnt <= (bit_cnt == 4'd8) ? 4'd0 : bit_cnt + 4'd1;

      if (state == ST_IDLE && start) begin
        rw_q      <= rw;
        nack_seen <= 1'b0;
        byte_cnt  <= (num_bytes > MAX_CNT) ? MAX_CNT : num_bytes;
      end else if ((state == ST_WRITE || state == ST_READ) && last_data_bit && byte_cnt != '0) begin
        byte_cnt <= byte_cnt - CNT_W'(1);
      end

      if (ack_state && sample)                     ack_bit   <= sda_in;
      if (ack_state && bit_end && ack_bit == NACK) nack_seen <= 1'b1;

      if (state == ST_IDLE && start)                            shift <= {slave_addr, rw};
      else if (wr_ready)                                        shift <= wr_data;
      else if (state == ST_READ && sample)                      shift <= {shift[6:0], sda_in};
      else if ((state == ST_ADDR || state == ST_WRITE) && bit_end) shift <= {shift[6:0], 1'b0};

      if (state == ST_READ && last_data_bit) rd_data <= shift;
    end
  end

endmodule

// File: doc/i2c_master_engine.md
I2C_MASTER_ENGINE -- requirements
Module: i2c_master_engine

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCL quarter-period, minimum 2.
REQ-002 SHALL have parameter MAX_BYTES, default 4: maximum data bytes per transaction, minimum 1.
REQ-003 SHALL have parameter CNT_W, default $clog2(MAX_BYTES+1): byte-count width.
REQ-004 SHALL have port clk  in  1  system clock; all logic runs on its rising edge.
REQ-005 SHALL have port rst_  in  1  reset; asynchronous assertion, active-low.
REQ-006 SHALL have port start  in  1  one-cycle request, accepted only while busy=0.
REQ-007 SHALL have port rw  in  1  1=read, 0=write; sampled with start.
REQ-008 SHALL have port slave_addr  in  7  target address; sampled with start.
REQ-009 SHALL have port num_bytes  in  CNT_W  data byte count; values above MAX_BYTES are clamped to MAX_BYTES; sampled with start.
REQ-010 SHALL have port wr_data  in  8  write byte; sampled on the cycle wr_ready=1.
REQ-011 SHALL have port wr_ready  out  1  one-cycle pulse when wr_data is captured.
REQ-012 SHALL have port rd_data  out  8  last received byte; held until the next byte.
REQ-013 SHALL have port rd_valid  out  1  one-cycle pulse when rd_data updates.
REQ-014 SHALL have ports busy, done, nack_err  out  1 each: busy = transaction in progress; done = completion pulse; nack_err = slave-NACK pulse, coincident with done.
REQ-015 SHALL have ports sda_in in 1, scl_out out 1, sda_out out 1, sda_select out 1 (0 = master drives sda_out, 1 = SDA released/sampled).

Function
REQ-016 Bit timing SHALL be 4 quarters of CLK_DIV cycles: q0,q1 SCL low; q2,q3 SCL high; SDA changes only at q0 start; sda_in sampled on the last cycle of q2.
REQ-017 FSM states SHALL be IDLE, START, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, STOP.
REQ-018 IDLE + start=1 SHALL latch the request, set busy=1 next cycle and enter START; start while busy=1 SHALL be ignored.
REQ-019 START SHALL hold SCL high and drive SDA low for 2 quarters, then drive SCL low, then enter ADDR.
REQ-020 ADDR SHALL send slave_addr[6:0] MSB first, followed by rw, then enter ADDR_ACK with sda_select=1.
REQ-021 ADDR_ACK: ACK (0) SHALL go to WRITE/READ per rw, or to STOP if num_bytes=0 (address probe); NACK SHALL go to STOP with nack_err.
REQ-022 WRITE SHALL pulse wr_ready on the first cycle of the byte, capture wr_data, send it MSB first, then enter WR_ACK.
REQ-023 WR_ACK: ACK with bytes remaining SHALL go to WRITE; ACK on the last byte SHALL go to STOP; NACK SHALL go to STOP immediately with nack_err.
REQ-024 READ SHALL shift in 8 bits MSB first with sda_select=1, update rd_data, pulse rd_valid at the end of bit 8, then enter RD_ACK.
REQ-025 RD_ACK SHALL drive 0 (ACK) when bytes remain, else 1 (NACK), then go to READ or STOP respectively.
REQ-026 STOP SHALL drive SDA low for one quarter with SCL low, raise SCL for one quarter, release SDA (sda_select=1, sda_out=1) for one quarter, then enter IDLE.
REQ-027 On entering IDLE, done SHALL pulse once, nack_err SHALL pulse only if a NACK occurred, and busy SHALL clear in the same cycle.
REQ-028 The bit counter SHALL count 0..8 and wrap to 0 per frame; the byte counter SHALL decrement per completed byte and never underflow.

Reset
REQ-029 While rst_=0, including mid-transaction, state SHALL be IDLE and outputs SHALL be scl_out=1, sda_out=1, sda_select=1, busy=0, done=0, nack_err=0, wr_ready=0, rd_valid=0, rd_data=0.
REQ-030 After rst_ deasserts, the first start SHALL be accepted on the next rising edge of clk.

Structure
REQ-031 Package i2c_pkg SHALL hold the state enumeration, quarter-phase encoding and the ACK/NACK constants.
REQ-032 Sub-module i2c_bit_timer SHALL generate quarter-phase and end-of-bit strobes from CLK_DIV.

Verification
REQ-033 CLK_DIV=4, write addr 0x5A, 2 bytes 0xA5/0x3C, slave ACKs all -> SDA shows 0xB4,0xA5,0x3C MSB first; 2 wr_ready pulses; done=1, nack_err=0; busy high for 2 quarters (START) + 27 bits x 16 cycles + 3 quarters (STOP).
REQ-034 Read 3 bytes, slave sends 0x11,0x22,0x33 -> 3 rd_valid pulses with those values; master ACK, ACK, NACK; then STOP.
REQ-035 Address NACK (sda_in=1 at ACK) -> no wr_ready pulse; STOP follows; done and nack_err pulse together.
REQ-036 num_bytes=0 probe with ACK -> address frame then STOP, done=1, nack_err=0; num_bytes=7 with MAX_BYTES=4 -> exactly 4 bytes transferred.
REQ-037 rst_ asserted during WRITE bit 4 -> scl_out, sda_out, sda_select all 1 and busy=0 immediately; a new start after release completes normally.
REQ-038 start pulsed during busy -> ignored; transaction content unchanged.
